// File: rtl/pkg_tpu.sv
// Shared TPU types: destination index, data word and the write-back issuer state.
package pkg_tpu;

    localparam int unsigned INDEX_W = 5;
    localparam int unsigned DATA_W  = 32;

    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef struct packed {
        logic   v;
        index_t idx;
    } dst_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_DONE
    } wb_iss_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order result FIFO; full is taken from the registered count, so a pop never frees a slot in the same cycle.
module wb_result_fifo
    import pkg_tpu::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  data_t data_in,
    output data_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    data_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/wb_stream_issuer.sv
// Drains queued execution results as a write-back stream of consecutive destination indices for one slice command.
module wb_stream_issuer
    import pkg_tpu::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   I_Stall,
    input  logic   I_Full,
    input  logic   I_Cmd_Valid,
    output logic   O_Cmd_Ready,
    input  dst_t   I_Cmd_Dst,
    input  index_t I_Slice_Len,
    input  logic   I_Res_Valid,
    input  data_t  I_Res_Data,
    output logic   O_Res_Ready,
    output dst_t   O_WB_Index,
    output data_t  O_WB_Data,
    output logic   O_Busy,
    output logic   O_Done
);

    wb_iss_state_t state;
    wb_iss_state_t state_next;
    index_t        base;
    index_t        len;
    index_t        cnt;
    logic          emit;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    data_t         head;

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (I_Res_Valid),
        .pop     (emit),
        .data_in (I_Res_Data),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign O_Res_Ready = ~fifo_full;

    always_comb begin
        state_next  = state;
        emit        = 1'b0;
        accept      = 1'b0;
        O_Cmd_Ready = 1'b0;
        case (state)
            WB_IDLE: begin
                O_Cmd_Ready = 1'b1;
                if (I_Cmd_Valid && I_Cmd_Dst.v) begin
                    accept     = 1'b1;
                    state_next = WB_RUN;
                end
            end
            WB_RUN: begin
                if (!fifo_empty && !I_Stall && !I_Full) begin
                    emit = 1'b1;
                    if (cnt == len) state_next = WB_DONE;
                end
            end
            WB_DONE: state_next = WB_IDLE;
            default: state_next = WB_IDLE;
        endcase
    end

    // Busy/done are registered alongside the stream so they line up with the elements they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= WB_IDLE;
            base       <= '0;
            len        <= '0;
            cnt        <= '0;
            O_WB_Index <= '0;
            O_WB_Data  <= '0;
            O_Busy     <= 1'b0;
            O_Done     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                base <= I_Cmd_Dst.idx;
                len  <= I_Slice_Len;
                cnt  <= '0;
            end
            if (emit) cnt <= cnt + INDEX_W'(1);
            O_WB_Index.v   <= emit;
            O_WB_Index.idx <= emit ? index_t'(base + cnt) : '0;
            O_WB_Data      <= emit ? head : '0;
            O_Busy         <= (state == WB_RUN);
            O_Done         <= (state == WB_DONE);
        end
    end

endmodule

// File: tb/tb_wb_stream_issuer.sv
// Directed bench for wb_stream_issuer: slices, stalls, FIFO full, index wrap, trickle with I_Full, mid-slice reset.
module tb_wb_stream_issuer;
    import pkg_tpu::*;

    logic   clock = 1'b0;
    logic   reset;
    logic   I_Stall, I_Full, I_Cmd_Valid, O_Cmd_Ready;
    dst_t   I_Cmd_Dst;
    index_t I_Slice_Len;
    logic   I_Res_Valid, O_Res_Ready;
    data_t  I_Res_Data;
    dst_t   O_WB_Index;
    data_t  O_WB_Data;
    logic   O_Busy, O_Done;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stream_issuer #(.FIFO_DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Stall     (I_Stall),
        .I_Full      (I_Full),
        .I_Cmd_Valid (I_Cmd_Valid),
        .O_Cmd_Ready (O_Cmd_Ready),
        .I_Cmd_Dst   (I_Cmd_Dst),
        .I_Slice_Len (I_Slice_Len),
        .I_Res_Valid (I_Res_Valid),
        .I_Res_Data  (I_Res_Data),
        .O_Res_Ready (O_Res_Ready),
        .O_WB_Index  (O_WB_Index),
        .O_WB_Data   (O_WB_Data),
        .O_Busy      (O_Busy),
        .O_Done      (O_Done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input index_t idx, input data_t d);
        chk({tag, ".v"}, 64'(O_WB_Index.v), 64'(v));
        chk({tag, ".idx"}, 64'(O_WB_Index.idx), 64'(idx));
        chk({tag, ".data"}, 64'(O_WB_Data), 64'(d));
    endtask

    task automatic push(input data_t d);
        I_Res_Valid = 1'b1;
        I_Res_Data  = d;
        tick();
        I_Res_Valid = 1'b0;
    endtask

    task automatic cmd(input index_t b, input index_t l);
        I_Cmd_Valid   = 1'b1;
        I_Cmd_Dst.v   = 1'b1;
        I_Cmd_Dst.idx = b;
        I_Slice_Len   = l;
        tick();
        I_Cmd_Valid = 1'b0;
        I_Cmd_Dst   = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk_wb(tag, 1'b0, '0, '0);
        chk({tag, ".busy"}, 64'(O_Busy), 64'd0);
        chk({tag, ".done"}, 64'(O_Done), 64'd0);
        chk({tag, ".cmd_ready"}, 64'(O_Cmd_Ready), 64'd1);
        chk({tag, ".res_ready"}, 64'(O_Res_Ready), 64'd1);
    endtask

    initial begin
        int     emitted;
        int     done_seen;
        int     pushed;
        logic   prev_full;
        data_t  f [3];

        reset = 1'b1; I_Stall = 0; I_Full = 0; I_Cmd_Valid = 0; I_Cmd_Dst = '0;
        I_Slice_Len = '0; I_Res_Valid = 0; I_Res_Data = '0;
        tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // Invalid destination is ignored.
        I_Cmd_Valid = 1'b1; I_Cmd_Dst = '{v: 1'b0, idx: 5'd9};
        tick();
        I_Cmd_Valid = 1'b0; I_Cmd_Dst = '0;
        tick();
        chk("ignored.busy", 64'(O_Busy), 64'd0);
        chk("ignored.cmd_ready", 64'(O_Cmd_Ready), 64'd1);

        // 1: basic slice.
        push(32'hD000_0000); push(32'hD000_0001); push(32'hD000_0002); push(32'hD000_0003);
        cmd(5'd5, 5'd3);
        chk("t1.cmd_ready_run", 64'(O_Cmd_Ready), 64'd0);
        tick(); chk_wb("t1.e0", 1, 5'd5, 32'hD000_0000); chk("t1.busy", 64'(O_Busy), 64'd1);
        tick(); chk_wb("t1.e1", 1, 5'd6, 32'hD000_0001);
        tick(); chk_wb("t1.e2", 1, 5'd7, 32'hD000_0002);
        tick(); chk_wb("t1.e3", 1, 5'd8, 32'hD000_0003); chk("t1.done_early", 64'(O_Done), 64'd0);
        chk("t1.cmd_ready_done", 64'(O_Cmd_Ready), 64'd0);
        tick(); chk_wb("t1.after", 0, '0, '0);
        chk("t1.done", 64'(O_Done), 64'd1); chk("t1.busy_drop", 64'(O_Busy), 64'd0);
        tick(); chk("t1.done_pulse", 64'(O_Done), 64'd0);

        // 2: two-cycle stall after the second element.
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        cmd(5'd5, 5'd3);
        tick(); chk_wb("t2.e0", 1, 5'd5, 32'hA0);
        tick(); chk_wb("t2.e1", 1, 5'd6, 32'hA1);
        I_Stall = 1'b1;
        tick(); chk_wb("t2.bub0", 0, '0, '0);
        tick(); chk_wb("t2.bub1", 0, '0, '0);
        I_Stall = 1'b0;
        tick(); chk_wb("t2.e2", 1, 5'd7, 32'hA2);
        tick(); chk_wb("t2.e3", 1, 5'd8, 32'hA3);
        tick(); chk("t2.done", 64'(O_Done), 64'd1); chk_wb("t2.after", 0, '0, '0);
        tick();

        // 3: fill FIFO, reject ninth result, drain eight in order.
        for (int i = 0; i < 8; i++) begin
            chk("t3.ready_fill", 64'(O_Res_Ready), 64'd1);
            push(data_t'(32'hB0 + i));
        end
        chk("t3.full", 64'(O_Res_Ready), 64'd0);
        push(32'hBAD);
        chk("t3.still_full", 64'(O_Res_Ready), 64'd0);
        cmd(5'd0, 5'd7);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_wb($sformatf("t3.e%0d", i), 1, index_t'(i), data_t'(32'hB0 + i));
        end
        tick(); chk("t3.done", 64'(O_Done), 64'd1); chk("t3.ready_back", 64'(O_Res_Ready), 64'd1);
        tick();

        // 4: index wrap; would also expose a wrongly accepted ninth result.
        push(32'hC0); push(32'hC1);
        cmd(5'd31, 5'd1);
        tick(); chk_wb("t4.e0", 1, 5'd31, 32'hC0);
        tick(); chk_wb("t4.e1", 1, 5'd0, 32'hC1);
        tick(); chk("t4.done", 64'(O_Done), 64'd1);
        tick();

        // 5: trickling results with I_Full toggling.
        f[0] = 32'hF0; f[1] = 32'hF1; f[2] = 32'hF2;
        cmd(5'd10, 5'd2);
        emitted = 0; done_seen = 0; pushed = 0; prev_full = 1'b0;
        for (int cyc = 0; cyc < 60 && done_seen == 0; cyc++) begin
            I_Res_Valid = (cyc % 3 == 0) && (pushed < 3);
            I_Res_Data  = (pushed < 3) ? f[pushed] : '0;
            I_Full      = cyc[0];
            prev_full   = I_Full;
            if (I_Res_Valid && O_Res_Ready) pushed++;
            tick();
            if (O_WB_Index.v) begin
                chk($sformatf("t5.full_gap%0d", emitted), 64'(prev_full), 64'd0);
                if (emitted < 3)
                    chk_wb($sformatf("t5.e%0d", emitted), 1, index_t'(10 + emitted), f[emitted]);
                emitted++;
            end
            if (O_Done) done_seen++;
        end
        I_Res_Valid = 1'b0; I_Full = 1'b0;
        chk("t5.count", 64'(emitted), 64'd3);
        chk("t5.done_seen", 64'(done_seen), 64'd1);
        tick();

        // 6: reset mid-slice, then a fresh slice.
        push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
        cmd(5'd20, 5'd3);
        tick(); chk_wb("t6.e0", 1, 5'd20, 32'hE0);
        tick(); chk_wb("t6.e1", 1, 5'd21, 32'hE1);
        reset = 1'b1;
        tick();
        chk_idle("t6.rst");
        reset = 1'b0;
        tick(); chk("t6.no_done", 64'(O_Done), 64'd0); chk_wb("t6.quiet", 0, '0, '0);
        push(32'h60); push(32'h61);
        cmd(5'd3, 5'd1);
        tick(); chk_wb("t6.n0", 1, 5'd3, 32'h60);
        tick(); chk_wb("t6.n1", 1, 5'd4, 32'h61);
        tick(); chk("t6.done", 64'(O_Done), 64'd1);
        tick(); chk_wb("t6.empty", 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
